// File: rtl/multicore_mem_arb_pkg.sv
// Shared constants and types for the multicore memory port arbiter.
package multicore_mem_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W        = $clog2(NUM_REQ_MAX);

  typedef enum logic {ARB, LOCKED} lock_state_t;

endpackage

// File: rtl/multicore_mem_port_arb_if.sv
// Requester-side Avalon-MM bundle for the memory port arbiter.
// m_lock exists only when MEM_ARB_LOCK_EN is defined.
interface multicore_mem_port_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ*ADDR_W-1:0]     m_address;
  logic [NUM_REQ-1:0]            m_read;
  logic [NUM_REQ-1:0]            m_write;
  logic [NUM_REQ*DATA_W-1:0]     m_writedata;
  logic [NUM_REQ*(DATA_W/8)-1:0] m_byteenable;
  logic [NUM_REQ-1:0]            m_waitrequest;
  logic [DATA_W-1:0]             m_readdata;
  logic [NUM_REQ-1:0]            m_readdatavalid;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            m_lock;
`endif

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output m_lock,
`endif
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  m_lock,
`endif
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid
  );

endinterface

// File: rtl/multicore_mem_arb_rr_pick.sv
// Rotate-priority picker: first active request at or after rr_ptr wins, wrapping to 0.
module multicore_mem_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    // upper segment [rr_ptr..NUM_REQ-1] first, then the wrapped segment [0..rr_ptr-1]
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (ID_W'(j) >= rr_ptr)) begin
        grant[j] = 1'b1;
        id       = ID_W'(j);
        any      = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (ID_W'(j) < rr_ptr)) begin
        grant[j] = 1'b1;
        id       = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicore_mem_port_arb.sv
// Round-robin arbiter sharing memory port s2 among NUM_REQ Avalon-MM requesters.
// Optional bus locking is enabled with MEM_ARB_LOCK_EN.
//   state  | meaning
//   ARB    | plain round-robin among all active requesters
//   LOCKED | only the recorded owner may be granted until it drops m_lock
module multicore_mem_port_arb
  import multicore_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  freeze,
  multicore_mem_port_arb_if.slave bus,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W/8;

  logic [ID_W-1:0]    rr_ptr, ptr_nxt, win_id, rd_id;
  logic               rd_pend, any, rd_accept;
  logic [NUM_REQ-1:0] active, eligible, grant;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ-1)) ? '0 : id + ID_W'(1);
  endfunction

  // write wins when both strobes are high
  assign active = bus.m_read | bus.m_write;

`ifdef MEM_ARB_LOCK_EN
  lock_state_t        state, state_nxt;
  logic [ID_W-1:0]    owner, owner_nxt;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_lock, win_lock, unlock;

  always_comb begin
    owner_mask = '0;
    owner_lock = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner == ID_W'(j)) begin
        owner_mask[j] = 1'b1;
        owner_lock    = bus.m_lock[j];
      end
    end
  end

  assign win_lock = |(grant & bus.m_lock);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unlock    = 1'b0;
    case (state)
      ARB: begin
        if (any && win_lock) begin
          state_nxt = LOCKED;
          owner_nxt = win_id;
        end
      end
      LOCKED: begin
        if (!owner_lock) begin
          state_nxt = ARB;
          unlock    = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  assign eligible = ((state == LOCKED) ? (active & owner_mask) : active)
                    & {NUM_REQ{reset_n & ~freeze}};
`else
  assign eligible = active & {NUM_REQ{reset_n & ~freeze}};
`endif

  multicore_mem_arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (eligible),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .id     (win_id),
    .any    (any)
  );

  always_comb begin
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        mem_address    = bus.m_address[j*ADDR_W +: ADDR_W];
        mem_writedata  = bus.m_writedata[j*DATA_W +: DATA_W];
        mem_byteenable = bus.m_byteenable[j*BE_W +: BE_W];
        mem_write      = bus.m_write[j];
      end
    end
  end

  assign mem_chipselect    = any;
  assign mem_clken         = reset_n;
  assign rd_accept         = any & ~mem_write;
  assign bus.m_waitrequest = ~grant;
  assign bus.m_readdata    = mem_readdata;

  always_comb begin
    bus.m_readdatavalid = '0;
    for (int j = 0; j < NUM_REQ; j++)
      bus.m_readdatavalid[j] = rd_pend && (rd_id == ID_W'(j));
  end

  always_comb begin
    ptr_nxt = rr_ptr;
    if (any) ptr_nxt = next_id(win_id);
`ifdef MEM_ARB_LOCK_EN
    if (unlock) ptr_nxt = next_id(owner);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      rr_ptr  <= ptr_nxt;
      rd_pend <= rd_accept;
      if (rd_accept) rd_id <= win_id;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      for (int j = 0; j < NUM_REQ; j++)
        assert (!(bus.m_read[j] && bus.m_write[j]))
          else $warning("requester %0d drives m_read and m_write together; treated as a write", j);
    end
  end

endmodule

// File: tb/tb_multicore_mem_port_arb.sv
// Directed bench for multicore_mem_port_arb with a one-cycle-latency memory model.
module tb_multicore_mem_port_arb;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          freeze = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic [BW-1:0] mem_byteenable;

  int checks = 0;
  int failures = 0;

  multicore_mem_port_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  multicore_mem_port_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .freeze         (freeze),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  // memory model: word i preloaded with 0xA0000000+i, registered read port
  logic [DW-1:0] mem [4096];
  logic          seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      seeded <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic set_req(input int r, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_read[r]                = rd;
    bus.m_write[r]               = wr;
    bus.m_address[r*AW +: AW]    = a;
    bus.m_writedata[r*DW +: DW]  = d;
    bus.m_byteenable[r*BW +: BW] = 4'hF;
  endtask

  task automatic clear_all();
    bus.m_read = '0;
    bus.m_write = '0;
  endtask

  initial begin
    bus.m_address = '0;
    bus.m_writedata = '0;
    bus.m_byteenable = '0;
    clear_all();
`ifdef MEM_ARB_LOCK_EN
    bus.m_lock = '0;
`endif

    // reset held with requester 0 active
    set_req(0, 1, 0, 12'h000, 32'h0);
    @(negedge clk); #2;
    check("rst_wait",   32'(bus.m_waitrequest),   32'hF);
    check("rst_cs",     32'(mem_chipselect),      32'h0);
    check("rst_clken",  32'(mem_clken),           32'h0);
    check("rst_rdv",    32'(bus.m_readdatavalid), 32'h0);

    @(negedge clk); clear_all(); reset_n = 1'b1; #2;
    check("idle_clken", 32'(mem_clken),           32'h1);
    check("idle_rdv",   32'(bus.m_readdatavalid), 32'h0);
    check("idle_wait",  32'(bus.m_waitrequest),   32'hF);
    check("idle_cs",    32'(mem_chipselect),      32'h0);

    // requester 2 write then read of 0x010
    @(negedge clk); set_req(2, 0, 1, 12'h010, 32'hDEAD_BEEF); #2;
    check("wr2_wait",  32'(bus.m_waitrequest), 32'hB);
    check("wr2_cs",    32'(mem_chipselect),    32'h1);
    check("wr2_we",    32'(mem_write),         32'h1);
    check("wr2_addr",  32'(mem_address),       32'h010);
    check("wr2_wdata", mem_writedata,          32'hDEAD_BEEF);
    check("wr2_be",    32'(mem_byteenable),    32'hF);

    @(negedge clk); set_req(2, 1, 0, 12'h010, 32'h0); #2;
    check("rd2_wait", 32'(bus.m_waitrequest),   32'hB);
    check("rd2_we",   32'(mem_write),           32'h0);
    check("rd2_rdv0", 32'(bus.m_readdatavalid), 32'h0);

    // rr_ptr is 3: requester 3 reads, while requester 2's data returns
    @(negedge clk); clear_all(); set_req(3, 1, 0, 12'h010, 32'h0); #2;
    check("rd2_rdv",   32'(bus.m_readdatavalid), 32'h4);
    check("rd2_data",  bus.m_readdata,           32'hDEAD_BEEF);
    check("rd3_wait",  32'(bus.m_waitrequest),   32'h7);

    @(negedge clk); clear_all(); #2;
    check("rd3_rdv",   32'(bus.m_readdatavalid), 32'h8);
    check("rd3_data",  bus.m_readdata,           32'hDEAD_BEEF);

    // all four read continuously: grants 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) for (int j = 0; j < N; j++) set_req(j, 1, 0, 12'(12'h100 + j), 32'h0);
      #2;
      check("rr_wait", 32'(bus.m_waitrequest), 32'(4'(~(4'b1 << (c % 4)))));
      check("rr_addr", 32'(mem_address),       32'h100 + 32'(c % 4));
      if (c == 0) begin
        check("rr_rdv0", 32'(bus.m_readdatavalid), 32'h0);
      end else begin
        check("rr_rdv",  32'(bus.m_readdatavalid), 32'(4'b1 << ((c - 1) % 4)));
        check("rr_data", bus.m_readdata,           32'hA000_0100 + 32'((c - 1) % 4));
      end
    end
    @(negedge clk); clear_all(); #2;
    check("rr_rdv_last",  32'(bus.m_readdatavalid), 32'h1);
    check("rr_data_last", bus.m_readdata,           32'hA000_0100);

    // requesters 1 and 3 assert both strobes: both become writes
    @(negedge clk);
    set_req(1, 1, 1, 12'h020, 32'h1111_2222);
    set_req(3, 1, 1, 12'h030, 32'h3333_4444);
    #2;
    check("dual1_wait", 32'(bus.m_waitrequest),   32'hD);
    check("dual1_we",   32'(mem_write),           32'h1);
    check("dual1_addr", 32'(mem_address),         32'h020);
    check("dual1_rdv",  32'(bus.m_readdatavalid), 32'h0);
    @(negedge clk); bus.m_read[1] = 1'b0; bus.m_write[1] = 1'b0; #2;
    check("dual3_wait",  32'(bus.m_waitrequest),   32'h7);
    check("dual3_we",    32'(mem_write),           32'h1);
    check("dual3_wdata", mem_writedata,            32'h3333_4444);
    check("dual3_rdv",   32'(bus.m_readdatavalid), 32'h0);
    @(negedge clk); clear_all(); #2;
    check("dual_rdv_after", 32'(bus.m_readdatavalid), 32'h0);
    check("dual_cs_after",  32'(mem_chipselect),      32'h0);

    // freeze for 3 cycles with requester 0 reading 0x020
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin freeze = 1'b1; set_req(0, 1, 0, 12'h020, 32'h0); end
      #2;
      check("frz_wait", 32'(bus.m_waitrequest), 32'hF);
      check("frz_cs",   32'(mem_chipselect),    32'h0);
    end
    @(negedge clk); freeze = 1'b0; #2;
    check("unfrz_wait", 32'(bus.m_waitrequest), 32'hE);
    check("unfrz_addr", 32'(mem_address),       32'h020);
    @(negedge clk); freeze = 1'b1; #2;
    check("frz_after_rd_wait", 32'(bus.m_waitrequest),   32'hF);
    check("frz_after_rd_rdv",  32'(bus.m_readdatavalid), 32'h1);
    check("frz_after_rd_data", bus.m_readdata,           32'h1111_2222);

    // reset pulsed right after a read accept drops the pending read
    @(negedge clk); freeze = 1'b0; #2;
    check("prerst_wait", 32'(bus.m_waitrequest), 32'hE);
    @(negedge clk); reset_n = 1'b0; clear_all(); #2;
    check("midrst_rdv",   32'(bus.m_readdatavalid), 32'h0);
    check("midrst_clken", 32'(mem_clken),           32'h0);
    @(negedge clk); reset_n = 1'b1; #2;
    check("postrst_rdv",  32'(bus.m_readdatavalid), 32'h0);
    @(negedge clk); set_req(0, 1, 0, 12'h000, 32'h0); set_req(3, 1, 0, 12'h000, 32'h0); #2;
    check("postrst_ptr0", 32'(bus.m_waitrequest), 32'hE);
    @(negedge clk); clear_all(); #2;
    check("postrst_rdv1", 32'(bus.m_readdatavalid), 32'h1);
    check("postrst_data", bus.m_readdata,           32'hA000_0000);

`ifdef MEM_ARB_LOCK_EN
    // rr_ptr is 1: requester 1 locks for 4 writes while requester 0 waits
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req(0, 1, 0, 12'h040, 32'h0);
      set_req(1, 0, 1, 12'(12'h050 + k), 32'h5555_0000 + 32'(k));
      bus.m_lock[1] = 1'b1;
      #2;
      check("lock_wait", 32'(bus.m_waitrequest), 32'hD);
      check("lock_addr", 32'(mem_address),       32'h050 + 32'(k));
    end
    @(negedge clk); bus.m_write[1] = 1'b0; bus.m_lock[1] = 1'b0; #2;
    check("unlock_wait", 32'(bus.m_waitrequest), 32'hF);
    check("unlock_cs",   32'(mem_chipselect),    32'h0);
    @(negedge clk); #2;
    check("after_lock_wait", 32'(bus.m_waitrequest), 32'hE);
    @(negedge clk); clear_all(); #2;
    check("after_lock_rdv",  32'(bus.m_readdatavalid), 32'h1);
    check("after_lock_data", bus.m_readdata,           32'hA000_0040);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
